// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Operation interface between the execute stage and muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
   parameter int WIDTH = 16
);
   logic             Start;
   logic [1:0]       MDOp;
   logic [WIDTH-1:0] Operand1;
   logic [WIDTH-1:0] Operand2;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] ResultHi;
   logic             Zero;
   logic             Busy;
   logic             Done;
   logic             DivByZero;
   logic             OpErr;

   modport master (
      output Start, MDOp, Operand1, Operand2,
      input  Result, ResultHi, Zero, Busy, Done, DivByZero, OpErr
   );

   modport slave (
      input  Start, MDOp, Operand1, Operand2,
      output Result, ResultHi, Zero, Busy, Done, DivByZero, OpErr
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative 16-bit multiply/divide, one bit per clock.
//            Divider is built only when MULDIV_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  wire logic Clk,
   input  wire logic Reset_n,
   muldiv_if.slave   bus
);
   localparam int         c_cw      = $clog2(WIDTH);
   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_fin  = 2'd2;

   logic [1:0]         r_state;
   logic [c_cw-1:0]    r_cnt;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_neg_lo;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_result_hi;
   logic               r_zero;
   logic               r_done;
   logic               r_dbz;
   logic               r_operr;

   logic               w_signed;
   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic [WIDTH:0]     w_add;
   logic [2*WIDTH-1:0] w_prod;

   assign w_signed = ~bus.MDOp[0];
   assign w_mag1   = (w_signed && bus.Operand1[WIDTH-1]) ? -bus.Operand1 : bus.Operand1;
   assign w_mag2   = (w_signed && bus.Operand2[WIDTH-1]) ? -bus.Operand2 : bus.Operand2;
   // Shift-add: r_hi accumulates, r_lo holds the multiplier shifting out LSB first
   assign w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : {(WIDTH+1){1'b0}});
   assign w_prod   = r_neg_lo ? -{r_hi, r_lo} : {r_hi, r_lo};

`ifdef MULDIV_DIV_EN
   logic               r_isdiv;
   logic               r_dbz_pend;
   logic               r_neg_hi;
   logic [WIDTH:0]     w_sh;
   logic [WIDTH+1:0]   w_diff;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   // Restoring divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in
   assign w_sh   = {r_hi, r_lo[WIDTH-1]};
   assign w_diff = {1'b0, w_sh} - {2'b00, r_mag};
   assign w_quo  = r_neg_lo ? -r_lo : r_lo;
   assign w_rem  = r_neg_hi ? -r_hi : r_hi;
`else
   logic               r_operr_pend;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= c_st_idle;
         r_cnt       <= '0;
         r_mag       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_neg_lo    <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_zero      <= 1'b0;
         r_done      <= 1'b0;
         r_dbz       <= 1'b0;
         r_operr     <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_isdiv     <= 1'b0;
         r_dbz_pend  <= 1'b0;
         r_neg_hi    <= 1'b0;
`else
         r_operr_pend <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (bus.Start) begin
                  r_lo     <= w_mag1;
                  r_hi     <= '0;
                  r_mag    <= w_mag2;
                  r_cnt    <= c_cw'(WIDTH-1);
                  r_neg_lo <= w_signed & (bus.Operand1[WIDTH-1] ^ bus.Operand2[WIDTH-1]);
                  r_state  <= c_st_run;
`ifdef MULDIV_DIV_EN
                  r_isdiv    <= bus.MDOp[1];
                  r_neg_hi   <= w_signed & bus.Operand1[WIDTH-1];
                  r_dbz_pend <= 1'b0;
                  if (bus.MDOp[1] && (bus.Operand2 == '0)) begin
                     r_lo       <= bus.Operand1;
                     r_dbz_pend <= 1'b1;
                     r_state    <= c_st_fin;
                  end
`else
                  r_operr_pend <= bus.MDOp[1];
                  if (bus.MDOp[1]) begin
                     r_state <= c_st_fin;
                  end
`endif
               end
            end

            c_st_run: begin
`ifdef MULDIV_DIV_EN
               if (r_isdiv) begin
                  if (!w_diff[WIDTH+1]) begin
                     r_hi <= w_diff[WIDTH-1:0];
                  end else begin
                     r_hi <= w_sh[WIDTH-1:0];
                  end
                  r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH+1]};
               end else begin
                  r_hi <= w_add[WIDTH:1];
                  r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
               end
`else
               r_hi <= w_add[WIDTH:1];
               r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
`endif
               if (r_cnt == '0) begin
                  r_state <= c_st_fin;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end

            c_st_fin: begin
               r_done  <= 1'b1;
               r_state <= c_st_idle;
               r_dbz   <= 1'b0;
               r_operr <= 1'b0;
`ifdef MULDIV_DIV_EN
               if (r_dbz_pend) begin
                  r_result    <= '1;
                  r_result_hi <= r_lo;
                  r_zero      <= 1'b0;
                  r_dbz       <= 1'b1;
               end else if (r_isdiv) begin
                  r_result    <= w_quo;
                  r_result_hi <= w_rem;
                  r_zero      <= (w_quo == '0);
               end else begin
                  r_result    <= w_prod[WIDTH-1:0];
                  r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_zero      <= (w_prod[WIDTH-1:0] == '0);
               end
`else
               if (r_operr_pend) begin
                  r_result    <= '0;
                  r_result_hi <= '0;
                  r_zero      <= 1'b1;
                  r_operr     <= 1'b1;
               end else begin
                  r_result    <= w_prod[WIDTH-1:0];
                  r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                  r_zero      <= (w_prod[WIDTH-1:0] == '0);
               end
`endif
            end

            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign bus.Result    = r_result;
   assign bus.ResultHi  = r_result_hi;
   assign bus.Zero      = r_zero;
   assign bus.Busy      = (r_state != c_st_idle);
   assign bus.Done      = r_done;
   assign bus.DivByZero = r_dbz;
   assign bus.OpErr     = r_operr;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit (both MULDIV_DIV_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
   logic Clk = 1'b0;
   logic Reset_n;
   int   checks   = 0;
   int   failures = 0;

   muldiv_if #(.WIDTH(16)) bus ();
   muldiv_unit #(.WIDTH(16)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge Clk);
      bus.Start    = 1'b1;
      bus.MDOp     = op;
      bus.Operand1 = a;
      bus.Operand2 = b;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      check("busy_after_e0", {31'd0, bus.Busy}, 32'd1);
   endtask

   // poke > 0 presents a junk Start so that it is sampled at edge E<poke>
   task automatic wait_done(input string tag, input int exp_lat, input int poke);
      int   cyc     = 0;
      logic busy_ok = 1'b1;
      logic seen    = 1'b0;
      while (cyc < 40 && !seen) begin
         @(posedge Clk);
         #1;
         cyc++;
         if (poke != 0 && cyc == poke - 1) begin
            bus.Start    = 1'b1;
            bus.MDOp     = 2'b01;
            bus.Operand1 = 16'h1234;
            bus.Operand2 = 16'h0100;
         end
         if (poke != 0 && cyc == poke) bus.Start = 1'b0;
         if (bus.Done === 1'b1) seen = 1'b1;
         else if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      end
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_busy_fall"}, {31'd0, bus.Busy}, 32'd0);
      @(posedge Clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, bus.Done}, 32'd0);
      check({tag, "_idle_after"}, {31'd0, bus.Busy}, 32'd0);
   endtask

   task automatic check_res(input string tag, input logic [15:0] res, input logic [15:0] hi,
                            input logic zero, input logic dbz, input logic operr);
      check({tag, "_result"},   {16'd0, bus.Result},    {16'd0, res});
      check({tag, "_resulthi"}, {16'd0, bus.ResultHi},  {16'd0, hi});
      check({tag, "_zero"},     {31'd0, bus.Zero},      {31'd0, zero});
      check({tag, "_divbyzero"},{31'd0, bus.DivByZero}, {31'd0, dbz});
      check({tag, "_operr"},    {31'd0, bus.OpErr},     {31'd0, operr});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
      check({tag, "_done"}, {31'd0, bus.Done}, 32'd0);
      check_res(tag, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.Start    = 1'b0;
      bus.MDOp     = 2'b00;
      bus.Operand1 = 16'h0000;
      bus.Operand2 = 16'h0000;
      Reset_n      = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check_all_zero("reset");
      @(negedge Clk);
      Reset_n = 1'b1;

      issue(2'b00, 16'd30, 16'd3);
      wait_done("mul_30x3", 17, 0);
      check_res("mul_30x3", 16'h005A, 16'h0000, 1'b0, 1'b0, 1'b0);

      issue(2'b00, 16'hFFF6, 16'd2);
      wait_done("mul_m10x2", 17, 0);
      check_res("mul_m10x2", 16'hFFEC, 16'hFFFF, 1'b0, 1'b0, 1'b0);

      issue(2'b01, 16'hFFFF, 16'hFFFF);
      wait_done("mulu_max", 17, 0);
      check_res("mulu_max", 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);

      issue(2'b00, 16'd7, 16'd5);
      wait_done("start_in_busy", 17, 5);
      check_res("start_in_busy", 16'h0023, 16'h0000, 1'b0, 1'b0, 1'b0);

      issue(2'b00, 16'd2, 16'd3);
      wait_done("start_at_fin", 17, 17);
      check_res("start_at_fin", 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Async reset in the middle of RUN
      issue(2'b00, 16'd30, 16'd3);
      repeat (8) @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      repeat (3) begin
         @(posedge Clk);
         #1;
         check("midrun_no_done", {31'd0, bus.Done}, 32'd0);
      end
      @(negedge Clk);
      Reset_n = 1'b1;

      issue(2'b00, 16'd30, 16'd3);
      wait_done("mul_after_reset", 17, 0);
      check_res("mul_after_reset", 16'h005A, 16'h0000, 1'b0, 1'b0, 1'b0);

`ifdef MULDIV_DIV_EN
      issue(2'b10, 16'd30, 16'hFFFC);
      wait_done("div_30_m4", 17, 0);
      check_res("div_30_m4", 16'hFFF9, 16'h0002, 1'b0, 1'b0, 1'b0);

      issue(2'b10, 16'hFFFF, 16'hFFF7);
      wait_done("div_m1_m9", 17, 0);
      check_res("div_m1_m9", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);

      issue(2'b10, 16'd10, 16'd0);
      wait_done("div_by_zero", 1, 0);
      check_res("div_by_zero", 16'hFFFF, 16'h000A, 1'b0, 1'b1, 1'b0);

      issue(2'b10, 16'h8000, 16'hFFFF);
      wait_done("div_wrap", 17, 0);
      check_res("div_wrap", 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0);

      issue(2'b11, 16'hFFFF, 16'h0010);
      wait_done("divu", 17, 0);
      check_res("divu", 16'h0FFF, 16'h000F, 1'b0, 1'b0, 1'b0);
`else
      issue(2'b10, 16'd30, 16'hFFFC);
      wait_done("div_disabled", 1, 0);
      check_res("div_disabled", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);

      issue(2'b11, 16'hFFFF, 16'h0000);
      wait_done("divu_disabled", 1, 0);
      check_res("divu_disabled", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);

      issue(2'b00, 16'd30, 16'd3);
      wait_done("mul_clears_operr", 17, 0);
      check_res("mul_clears_operr", 16'h005A, 16'h0000, 1'b0, 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
